// File: rtl/ring_pkg.sv
// Shared constants for the ring NIC: widths, register map, packet fields, polarity.
package ring_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned CNT_W   = 8;

  // Packet header field positions
  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;

  // Processor register map
  localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'b11;

  // Router polarity encodings
  localparam logic POL_ODD  = 1'b0;
  localparam logic POL_EVEN = 1'b1;

  // Output path FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

endpackage

// File: rtl/ring_nic_buf.sv
// nic_buf: one packet-wide data register with a full flag; load wins over clear.
module nic_buf
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  // Capture data and set full on load; drop full on clear
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_nic.sv
// ring_nic: processor-facing NIC for the ring router PE port.
// Optional macro NIC_DROP_CNT_EN adds a saturating drop/protocol-error counter
// visible in the output status word bits [8+CNT_W-1:8].
module ring_nic
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_polarity,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [DATA_W-1:0] in_buf;
  logic [DATA_W-1:0] out_buf;
  logic              in_full;
  logic              out_full;
  logic              in_load;
  logic              in_clear;
  logic              out_load;
  logic              out_clear;
  logic              rd_en;
  logic              wr_out;
  logic [DATA_W-1:0] out_stat;

  assign rd_en    = nicEn && !nicWrEn;
  assign wr_out   = nicEn && nicWrEn && (addr == ADDR_OUT_BUF);
  assign in_load  = net_si && !in_full;
  assign in_clear = rd_en && (addr == ADDR_IN_BUF) && in_full;
  assign net_ri   = !in_full;
  assign net_do   = out_buf;

  nic_buf u_in_buf (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clear (in_clear),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  nic_buf u_out_buf (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clear (out_clear),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Output FSM: accept a packet when idle, send it in its own VC polarity phase
  always_comb begin
    state_next = state;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    net_so     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_out) begin
          out_load   = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        net_so = net_ro && (net_polarity == out_buf[VC_BIT]);
        if (net_so) begin
          out_clear  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef NIC_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic             drop_wr;
  logic             arrive_err;
  logic             stat_wr;

  assign drop_wr    = wr_out && (state == ST_PEND);
  assign arrive_err = net_si && in_full;
  assign stat_wr    = nicEn && nicWrEn && (addr == ADDR_OUT_STAT);
  assign cnt_sum    = (CNT_W+1)'(drop_cnt) + (CNT_W+1)'(drop_wr) + (CNT_W+1)'(arrive_err);

  // Saturating count of dropped writes and router protocol errors
  always_ff @(posedge clk) begin
    if (reset || stat_wr)  drop_cnt <= '0;
    else if (cnt_sum[CNT_W]) drop_cnt <= '1;
    else                     drop_cnt <= cnt_sum[CNT_W-1:0];
  end

  assign out_stat = DATA_W'(out_full) | (DATA_W'(drop_cnt) << 8);
`else
  assign out_stat = DATA_W'(out_full);
`endif

  // Zero-latency register read mux
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:   d_out = in_buf;
        ADDR_IN_STAT:  d_out = DATA_W'(in_full);
        ADDR_OUT_STAT: d_out = out_stat;
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Directed self-checking bench for ring_nic with packet scoreboards per direction.
module tb_ring_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_polarity;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int errors = 0;
  int checks = 0;
  bit tog    = 1'b0;
  bit sent;
  logic [63:0] out_q[$];
  logic [63:0] in_q[$];
  logic [63:0] exp_pkt;

  ring_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_polarity (net_polarity),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; optionally flip polarity
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) net_polarity = ~net_polarity;
  endtask

  // Combinational register read with no clock edge in between
  task automatic rchk(input logic [1:0] a, input logic [63:0] exp, input string tag);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
    chk(tag, d_out, exp);
    nicEn = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
  endtask

  task automatic pop_out(input string tag);
    if (out_q.size() == 0) chk({tag, "_q_empty"}, 64'd1, 64'd0);
    else begin
      exp_pkt = out_q.pop_front();
      chk(tag, net_do, exp_pkt);
    end
  endtask

  initial begin
    reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_polarity = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_ri", 64'(net_ri), 64'd1);
    chk("rst_do", net_do, 64'd0);
    chk("rst_dout_idle", d_out, 64'd0);
    rchk(2'b01, 64'd0, "rst_in_stat");
    rchk(2'b11, 64'd0, "rst_out_stat");
    rchk(2'b00, 64'd0, "rst_in_buf");

    // Odd-VC packet with toggling polarity starting at 0
    tick();
    net_ro = 1'b1; tog = 1'b1;
    drive_wr(2'b10, 64'h0000_0000_0000_00AA);
    out_q.push_back(64'h0000_0000_0000_00AA);
    tick();
    nicEn = 1'b0;
    @(negedge clk);
    chk("p1_gap_pol", 64'(net_polarity), 64'd1);
    chk("p1_no_send_pol1", 64'(net_so), 64'd0);
    chk("p1_do", net_do, 64'hAA);
    rchk(2'b11, 64'd1, "p1_out_full");
    tick();
    @(negedge clk);
    chk("p1_send_pol0", 64'(net_so), 64'd1);
    pop_out("p1_pkt");
    tick();
    @(negedge clk);
    chk("p1_so_after", 64'(net_so), 64'd0);
    rchk(2'b11, 64'd0, "p1_out_clear");

    // Even-VC packet held by router backpressure, plus a dropped write
    tick();
    net_ro = 1'b0;
    drive_wr(2'b10, 64'h8001_0000_0000_0001);
    out_q.push_back(64'h8001_0000_0000_0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) drive_wr(2'b10, 64'h0000_0000_0000_1234);
      else        nicEn = 1'b0;
      @(negedge clk);
      chk("p2_stall", 64'(net_so), 64'd0);
    end
    tick();
    nicEn = 1'b0;
    net_ro = 1'b1;
    @(negedge clk);
    chk("p2_keep_orig", net_do, 64'h8001_0000_0000_0001);
    sent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sent) begin
        if (i != 0) @(negedge clk);
        if (net_polarity) begin
          chk("p2_send_pol1", 64'(net_so), 64'd1);
          pop_out("p2_pkt");
          sent = 1'b1;
        end else begin
          chk("p2_wait_pol0", 64'(net_so), 64'd0);
        end
        tick();
      end
    end
    if (!sent) chk("p2_send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("p2_so_after", 64'(net_so), 64'd0);
`ifdef NIC_DROP_CNT_EN
    rchk(2'b11, 64'h100, "p3_drop_cnt");
    tick();
    drive_wr(2'b11, 64'd0);
    tick();
    nicEn = 1'b0;
    @(negedge clk);
    rchk(2'b11, 64'd0, "p3_cnt_clear");
`else
    rchk(2'b11, 64'd0, "p3_stat_plain");
`endif

    // Input path: capture, protocol-error second send, read and clear
    tick();
    net_si = 1'b1; net_di = 64'h55;
    in_q.push_back(64'h55);
    tick();
    net_si = 1'b0;
    @(negedge clk);
    chk("p4_ri_full", 64'(net_ri), 64'd0);
    rchk(2'b01, 64'd1, "p4_in_full");
    tick();
    net_si = 1'b1; net_di = 64'hEE;
    tick();
    net_si = 1'b0;
    @(negedge clk);
    rchk(2'b01, 64'd1, "p5_still_full");
    tick();
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    @(negedge clk);
    exp_pkt = in_q.pop_front();
    chk("p4_read_pkt", d_out, exp_pkt);
    tick();
    nicEn = 1'b0;
    @(negedge clk);
    chk("p4_ri_after", 64'(net_ri), 64'd1);
    rchk(2'b01, 64'd0, "p4_in_cleared");
    rchk(2'b00, 64'h55, "p4_stale_read");
    rchk(2'b01, 64'd0, "p4_stale_no_flag");
    rchk(2'b10, 64'd0, "p4_read_outbuf_zero");
`ifdef NIC_DROP_CNT_EN
    rchk(2'b11, 64'h100, "p5_err_cnt");
`else
    rchk(2'b11, 64'd0, "p5_stat_plain");
`endif

    // Reset while a packet is pending and the input buffer is full
    tick();
    net_ro = 1'b0;
    drive_wr(2'b10, 64'h8000_0000_0000_0002);
    net_si = 1'b1; net_di = 64'h77;
    tick();
    nicEn = 1'b0; net_si = 1'b0;
    @(negedge clk);
    rchk(2'b11, 64'd1, "p6_pend");
    rchk(2'b01, 64'd1, "p6_full");
    tick();
    reset = 1'b1; net_ro = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("p6_so", 64'(net_so), 64'd0);
    chk("p6_ri", 64'(net_ri), 64'd1);
    chk("p6_do", net_do, 64'd0);
    rchk(2'b01, 64'd0, "p6_in_stat");
    rchk(2'b11, 64'd0, "p6_out_stat");
    rchk(2'b00, 64'd0, "p6_in_buf");
    tick();
    @(negedge clk);
    chk("p6_no_late_send", 64'(net_so), 64'd0);
    chk("sb_out_drained", 64'(out_q.size()), 64'd0);
    chk("sb_in_drained", 64'(in_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller between a processing element and the PE port of the ring router.
- Exposes a small 2-bit register map to the processor:
  - output buffer, written to inject a packet;
  - input buffer, read to eject a packet;
  - two status words.
- Router side speaks the router's send/ready/data handshake and honours its even/odd virtual-channel polarity.
- One 64-bit buffer per direction, each with a full flag.

Parameters:
- DATA_W, 64, packet/register width.
- ADDR_W, 2, processor address width.
- VC_BIT, 63, packet bit selecting virtual channel (0 = odd, sent while polarity=0; 1 = even, sent while polarity=1).
- CNT_W, 8, width of drop counter (optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_W  processor register address.
- d_in  in  DATA_W  processor write data.
- d_out  out  DATA_W  processor read data.
- nicEn  in  1  processor access strobe.
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn).
- net_polarity  in  1  router polarity.
- net_so  out  1  send to router PE input (router pesi).
- net_ro  in  1  router ready (router peri).
- net_do  out  DATA_W  packet to router (router pedi).
- net_si  in  1  router sending (router peso).
- net_ri  out  1  NIC ready to receive (router pero).
- net_di  in  DATA_W  packet from router (router pedo).

Behaviour:
- Register map:
  - 00: read input buffer.
  - 01: input status, bit0 = in_full, others 0.
  - 10: write output buffer.
  - 11: output status, bit0 = out_full, others 0.
  - Writes to 00/01/11 and reads of 10 have no effect; such reads return 0.
- d_out is combinational from addr when nicEn && ~nicWrEn, else 0. No read latency.
- Reset: in_full=0, out_full=0, in_buf=0, out_buf=0, state=IDLE, net_so=0, net_ri=1, d_out=0, net_do=0.
- Input path:
  - net_ri = ~in_full, combinational.
  - At posedge with net_si && ~in_full: in_buf<=net_di, in_full<=1.
  - Processor read of 00 while in_full clears in_full at that edge.
  - Read of 00 while empty returns stale in_buf and leaves flags unchanged.
  - Capture and clear cannot coincide (ri=0 while full).
- Output path FSM states:
  - IDLE (out_full=0): processor write to 10 loads out_buf<=d_in, go to PEND.
  - PEND (out_full=1): net_so = net_ro && (net_polarity == out_buf[VC_BIT]), combinational. At an edge where net_so=1, go to IDLE, out_full<=0.
  - Write to 10 while PEND: dropped, out_buf unchanged.
- Write to 10 in IDLE in the same edge as nothing pending: one-cycle minimum gap before net_so can assert (loaded at edge N, earliest send sampled at edge N+1).
- net_do = out_buf at all times.
- The NIC does not modify the hop count (bits 55:48) or the direction bit 62; the processor prepares the header.
- Reset mid-transfer: both buffers are emptied; a packet pending in PEND is lost; no partial send.

Optional Feature:
- Macro NIC_DROP_CNT_EN.
- With it:
  - CNT_W-bit saturating counter of writes to 10 dropped while PEND.
  - Also counts packets arriving while in_full with net_si=1 (router must not do this; flags protocol error).
  - Readable in status word 11 bits [8+CNT_W-1:8].
  - Cleared by reset or by any write to 11.
- Without it: those bits read 0 and no counter logic exists.

Decomposition:
- Shared package ring_pkg holds:
  - address constants ADDR_IN_BUF, ADDR_IN_STAT, ADDR_OUT_BUF, ADDR_OUT_STAT;
  - packet field positions VC_BIT=63, DIR_BIT=62, HOP_MSB=55, HOP_LSB=48;
  - polarity encodings POL_ODD=0, POL_EVEN=1.
- One natural sub-module, nic_buf: 64-bit data register with full flag, load and clear inputs. Instantiated twice.

Test Plan:
- Write 10 with 0x0000_0000_0000_00AA, net_ro=1, net_polarity toggling from 0 after reset:
  - net_so asserts only on polarity=0 cycles;
  - net_do=0xAA;
  - out_full clears after the first such edge.
- Write 10 with VC_BIT=1 packet 0x8001_0000_0000_0001 while net_ro=0 for 4 cycles:
  - no send;
  - then net_ro=1: net_so asserts on the first polarity=1 cycle.
- While PEND, write 10 with 0x1234: out_buf keeps the original packet; with NIC_DROP_CNT_EN, status 11 reads 0x100.
- net_si=1 with net_di=0x55:
  - in_full=1 and net_ri=0 next cycle;
  - read 00 returns 0x55 and clears in_full;
  - net_ri=1 the following cycle.
- Second net_si while in_full: buffer keeps the first packet; drop counter increments if enabled.
- Reset asserted while PEND and in_full: next cycle net_so=0, net_ri=1, status 01 and 11 read 0.
